// File: rtl/wb_nor_bus_ctrl.sv
// Pipelined Wishbone slave driving an asynchronous parallel NOR flash.
// Optional macro NOR_BUSY_TIMEOUT_EN: answer a request stalled on RY/BY# with wb_err_o after TIMEOUT cycles.
module wb_nor_bus_ctrl #(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16,
  parameter int RD_WAIT  = 7,
  parameter int SETUP    = 1,
  parameter int WR_PULSE = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [DATABITS-1:0] wb_dat_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_stall_o,
  output logic [DATABITS-1:0] wb_dat_o,
  output logic [ADDRBITS-1:0] nor_addr_o,
  output logic [DATABITS-1:0] nor_data_o,
  output logic                nor_data_oe_o,
  input  logic [DATABITS-1:0] nor_data_i,
  input  logic                nor_ry_by_i,
  output logic                nor_ce_n_o,
  output logic                nor_oe_n_o,
  output logic                nor_we_n_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_ACK, S_ERR
  } state_t;

  localparam int MAXC = (RD_WAIT > SETUP) ? ((RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE)
                                          : ((SETUP > WR_PULSE) ? SETUP : WR_PULSE);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ry_meta_q, ready_q;
  logic [ADDRBITS-1:0]   addr_q;
  logic [DATABITS-1:0]   wdata_q, rdata_q;
  logic                  abort_q;
  logic                  accept, adr_bad, rd_last, tmo_hit;

  assign accept  = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign adr_bad = |wb_adr_i[31:ADDRBITS];
  assign rd_last = (state_q == S_RD) && (cnt_q == CW'(RD_WAIT - 1));

`ifdef NOR_BUSY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic          busy_req;

  assign busy_req = (state_q == S_IDLE) && wb_cyc_i && wb_stb_i && !ready_q;
  assign tmo_hit  = busy_req && (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i || !busy_req || tmo_hit) tmo_q <= '0;
    else                                  tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ry_meta_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ry_meta_q <= nor_ry_by_i;
      ready_q   <= ry_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tmo_hit)                  state_d = S_ERR;
        else if (accept && adr_bad)   state_d = S_ERR;
        else if (accept && wb_we_i)   state_d = S_WR_SETUP;
        else if (accept)              state_d = S_RD;
      end
      S_RD: begin
        cnt_d = cnt_q + 1'b1;
        if (rd_last) begin
          state_d = S_ACK;
          cnt_d   = '0;
        end
      end
      S_WR_SETUP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SETUP - 1)) begin
          state_d = S_WR_PULSE;
          cnt_d   = '0;
        end
      end
      S_WR_PULSE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WR_PULSE - 1)) begin
          state_d = S_WR_HOLD;
          cnt_d   = '0;
        end
      end
      S_WR_HOLD: state_d = S_ACK;
      default:   state_d = S_IDLE;
    endcase
  end

  // A dropped cycle only masks the response; the flash access runs to completion.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      abort_q <= 1'b0;
    end else begin
      if (accept && !adr_bad && !tmo_hit) begin
        addr_q  <= wb_adr_i[ADDRBITS-1:0];
        wdata_q <= wb_dat_i;
      end
      if (rd_last) rdata_q <= nor_data_i;
      if (accept || tmo_hit)                    abort_q <= 1'b0;
      else if (state_q != S_IDLE && !wb_cyc_i) abort_q <= 1'b1;
    end
  end

  always_comb begin
    wb_stall_o    = 1'b1;
    wb_ack_o      = 1'b0;
    wb_err_o      = 1'b0;
    nor_ce_n_o    = 1'b1;
    nor_oe_n_o    = 1'b1;
    nor_we_n_o    = 1'b1;
    nor_data_oe_o = 1'b0;
    case (state_q)
      S_IDLE:     wb_stall_o = ~ready_q;
      S_RD: begin
        nor_ce_n_o = 1'b0;
        nor_oe_n_o = 1'b0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        nor_ce_n_o    = 1'b0;
        nor_data_oe_o = 1'b1;
      end
      S_WR_PULSE: begin
        nor_ce_n_o    = 1'b0;
        nor_we_n_o    = 1'b0;
        nor_data_oe_o = 1'b1;
      end
      S_ACK:      wb_ack_o = wb_cyc_i & ~abort_q;
      S_ERR:      wb_err_o = wb_cyc_i & ~abort_q;
      default:    wb_stall_o = 1'b1;
    endcase
  end

  assign wb_dat_o   = rdata_q;
  assign nor_addr_o = addr_q;
  assign nor_data_o = wdata_q;

endmodule
